// File: rtl/rom_loader.sv
// Byte-stream program loader: parses LEN_LO, LEN_HI, 4*N data bytes and CHK,
// writes each little-endian word to instruction RAM and holds the CPU until the checksum matches.
module rom_loader #(
  parameter  int profundidad = 1024,
  localparam int AW          = $clog2(profundidad)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are
  // both 1; rx_ready depends only on the FSM state, never on rx_valid.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(profundidad);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_len;
  logic [15:0]   r_word_idx;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_word;
  logic [7:0]    r_chk;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_rdy;
  logic          w_xfer;
  logic [15:0]   w_len_full;
  logic          w_last_word;

  assign w_rdy       = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CHK);
  assign w_xfer      = rx_valid & w_rdy;
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_last_word = (r_word_idx == (r_len - 16'd1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LEN0;
      S_LEN0: if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len_full == 16'd0)                w_next = S_CHK;
          else if ({1'b0, w_len_full} > LP_DEPTH) w_next = S_ERR;
          else                                    w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && (r_byte_cnt == 2'd3) && w_last_word) w_next = S_CHK;
      S_CHK:  if (w_xfer) w_next = (rx_data == r_chk) ? S_DONE : S_ERR;
      S_DONE: if (start) w_next = S_LEN0;
      S_ERR:  if (start) w_next = S_LEN0;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_chk      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // Arming a new load starts the frame from a clean slate.
          if (start) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_chk      <= '0;
          end
        end
        S_LEN0: begin
          if (w_xfer) begin
            r_len[7:0] <= rx_data;
            r_chk      <= r_chk ^ rx_data;
          end
        end
        S_LEN1: begin
          if (w_xfer) begin
            r_len[15:8] <= rx_data;
            r_chk       <= r_chk ^ rx_data;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_chk      <= r_chk ^ rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word; it is written on the next cycle.
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_word_idx[AW-1:0];
                r_wr_data  <= {rx_data, r_word};
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready = w_rdy;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign cpu_hold = (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERR);

endmodule
